cam_lutram_writer: RTL and testbench

CAM_LUTRAM_WRITER -- requirements
Module: cam_lutram_writer

---
 rtl/cam_lutram_writer_if.sv | 23 ++
 rtl/cam_lutram_writer.sv | 142 ++++++++++++++
 tb/tb_cam_lutram_writer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_lutram_writer_if.sv
// Request channel into the CAM writer: valid/ready handshake carrying op, target index and key.
interface cam_lutram_writer_if #(
    parameter int ENTRIES         = 8,
    parameter int PACKS_OF_5_BITS = 4
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic                            req_valid_i;
    logic                            req_ready_o;
    logic                            req_op_i;
    logic [IW-1:0]                   req_idx_i;
    logic [PACKS_OF_5_BITS-1:0][4:0] req_key_i;

    modport master (
        output req_valid_i, req_op_i, req_idx_i, req_key_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_idx_i, req_key_i,
        output req_ready_o
    );
endinterface

// File: rtl/cam_lutram_writer.sv
// Sequences writes into a LUTRAM-based CAM: clears on init/flush, evicts duplicate keys,
// and spaces update pulses so the CAM's two-cycle write settles before results are trusted.
module cam_lutram_writer #(
    parameter int ENTRIES         = 8,
    parameter int PACKS_OF_5_BITS = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    cam_lutram_writer_if.slave                           req,
    input  logic                                         flush_i,
    output logic [ENTRIES-1:0]                           cam_update_o,
    output logic [PACKS_OF_5_BITS-1:0][4:0]              cam_set_key_o,
    output logic                                         cam_set_valid_o,
    input  logic [ENTRIES-1:0][PACKS_OF_5_BITS-1:0][4:0] cam_key_i,
    output logic [ENTRIES-1:0]                           entry_valid_o,
    output logic                                         stable_o,
    output logic                                         done_o
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef logic [PACKS_OF_5_BITS-1:0][4:0] key_t;
    typedef enum logic [2:0] {
        INIT, IDLE, DUP_ISSUE, DUP_SETTLE, ISSUE, SETTLE, DONE
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] init_idx;
    logic          init_phase;
    logic          flush_pend;
    logic          accept;
    logic          dup_hit;
    logic [IW-1:0] dup_sel;

    logic [IW-1:0] idx_q;
    logic [IW-1:0] dup_q;
    logic          op_q;
    key_t          key_q;

    function automatic logic [ENTRIES-1:0] onehot(input logic [IW-1:0] i);
        logic [ENTRIES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Lowest valid entry other than the target already holding the requested key.
    always_comb begin
        dup_hit = 1'b0;
        dup_sel = '0;
        for (int j = ENTRIES - 1; j >= 0; j--) begin
            if (entry_valid_o[j] && (cam_key_i[j] == req.req_key_i) && (IW'(j) != req.req_idx_i)) begin
                dup_hit = 1'b1;
                dup_sel = IW'(j);
            end
        end
    end

    assign req.req_ready_o = ((state == IDLE) || (state == DONE)) && !flush_i && !flush_pend;
    assign accept          = req.req_ready_o && req.req_valid_i;
    assign stable_o        = (state == IDLE) || (state == DONE);
    assign done_o          = (state == DONE);

    // With a power-of-two entry count every index is in range, so no out-of-range path exists.
    always_comb begin
        state_n = state;
        case (state)
            INIT:       if (init_phase && (init_idx == IW'(ENTRIES - 1))) state_n = IDLE;
            IDLE, DONE: begin
                if (flush_i || flush_pend)              state_n = INIT;
                else if (accept)                        state_n = (req.req_op_i && dup_hit) ? DUP_ISSUE : ISSUE;
                else if (state == DONE)                 state_n = IDLE;
            end
            DUP_ISSUE:  state_n = DUP_SETTLE;
            DUP_SETTLE: state_n = ISSUE;
            ISSUE:      state_n = SETTLE;
            SETTLE:     state_n = DONE;
            default:    state_n = INIT;
        endcase
    end

    // Update pulse and its payload; gated by reset so nothing leaks out while held.
    always_comb begin
        cam_update_o    = '0;
        cam_set_key_o   = '0;
        cam_set_valid_o = 1'b0;
        if (rst_n) begin
            case (state)
                INIT: if (!init_phase) cam_update_o = onehot(init_idx);
                DUP_ISSUE: begin
                    cam_update_o  = onehot(dup_q);
                    cam_set_key_o = cam_key_i[dup_q];
                end
                ISSUE: begin
                    cam_update_o    = onehot(idx_q);
                    cam_set_key_o   = op_q ? key_q : cam_key_i[idx_q];
                    cam_set_valid_o = op_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_idx      <= '0;
            init_phase    <= 1'b0;
            flush_pend    <= 1'b0;
            entry_valid_o <= '0;
        end else begin
            state <= state_n;
            if (state == INIT) begin
                init_phase <= ~init_phase;
                if (init_phase) init_idx <= init_idx + 1'b1;
            end else if (state_n == INIT) begin
                init_idx   <= '0;
                init_phase <= 1'b0;
            end

            if (state_n == INIT)
                flush_pend <= 1'b0;
            else if (flush_i && (state != IDLE) && (state != DONE) && (state != INIT))
                flush_pend <= 1'b1;

            if (state_n == INIT)
                entry_valid_o <= '0;
            else if (state == DUP_ISSUE)
                entry_valid_o[dup_q] <= 1'b0;
            else if (state == ISSUE)
                entry_valid_o[idx_q] <= op_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= req.req_idx_i;
            op_q  <= req.req_op_i;
            key_q <= req.req_key_i;
            dup_q <= dup_sel;
        end
    end
endmodule

// File: tb/tb_cam_lutram_writer.sv
// Directed bench for cam_lutram_writer with a behavioural two-cycle-write CAM key store.
module tb_cam_lutram_writer;
    localparam int E = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    logic [E-1:0]             cam_update_o;
    logic [P-1:0][4:0]        cam_set_key_o;
    logic                     cam_set_valid_o;
    logic [E-1:0][P-1:0][4:0] cam_mem;
    logic [E-1:0]             entry_valid_o;
    logic                     stable_o;
    logic                     done_o;

    int vectors = 0;
    int miscompares = 0;
    int proto_viol = 0;

    cam_lutram_writer_if #(.ENTRIES(E), .PACKS_OF_5_BITS(P)) rif ();

    cam_lutram_writer #(.ENTRIES(E), .PACKS_OF_5_BITS(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (rif),
        .flush_i         (flush_i),
        .cam_update_o    (cam_update_o),
        .cam_set_key_o   (cam_set_key_o),
        .cam_set_valid_o (cam_set_valid_o),
        .cam_key_i       (cam_mem),
        .entry_valid_o   (entry_valid_o),
        .stable_o        (stable_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    // CAM key store: old key cleared at end of pulse cycle, new key written one cycle later.
    logic [E-1:0]      pend_upd = '0;
    logic [P-1:0][4:0] pend_key = '0;
    initial cam_mem = '0;
    always @(posedge clk) begin
        for (int i = 0; i < E; i++) begin
            if (pend_upd[i]) cam_mem[i] <= pend_key;
            if (cam_update_o[i]) cam_mem[i] <= '0;
        end
        pend_upd <= cam_update_o;
        pend_key <= cam_set_key_o;
    end

    // Pulse rules: at most one-hot, payload zero when idle, never the same entry twice in a row.
    logic [E-1:0] prev_upd = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(cam_update_o) > 1) proto_viol++;
            if ((cam_update_o == '0) && ((cam_set_key_o != '0) || cam_set_valid_o)) proto_viol++;
            if ((cam_update_o & prev_upd) != '0) proto_viol++;
            prev_upd = cam_update_o;
        end else begin
            prev_upd = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        #1;
        while (!rif.req_ready_o && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(rif.req_ready_o), 32'd1);
    endtask

    // Present a request, wait for acceptance, return in the cycle after the accept edge.
    task automatic send(input logic op, input logic [2:0] idx, input logic [19:0] key);
        rif.req_valid_i = 1'b1;
        rif.req_op_i    = op;
        rif.req_idx_i   = idx;
        rif.req_key_i   = key;
        wait_ready("accept");
        tick();
        rif.req_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        rif.req_valid_i = 1'b0;
        rif.req_op_i = 1'b0;
        rif.req_idx_i = '0;
        rif.req_key_i = '0;
        tick();
        tick();
        chk("rst_upd", 32'(cam_update_o), 32'h0);
        chk("rst_ready", 32'(rif.req_ready_o), 32'd0);
        chk("rst_stable", 32'(stable_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ev", 32'(entry_valid_o), 32'h0);

        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 16; c++) begin
            chk("init_upd", 32'(cam_update_o), (c % 2 == 0) ? (32'd1 << (c / 2)) : 32'd0);
            chk("init_vld", 32'(cam_set_valid_o), 32'd0);
            tick();
        end
        chk("init_ready", 32'(rif.req_ready_o), 32'd1);
        chk("init_stable", 32'(stable_o), 32'd1);

        // Plain insert
        send(1'b1, 3'd3, 20'h12345);
        chk("ins_upd", 32'(cam_update_o), 32'h08);
        chk("ins_vld", 32'(cam_set_valid_o), 32'd1);
        chk("ins_key", 32'(cam_set_key_o), 32'h12345);
        chk("ins_stable", 32'(stable_o), 32'd0);
        tick();
        chk("ins_settle", 32'(cam_update_o), 32'h0);
        chk("ins_settle_done", 32'(done_o), 32'd0);
        tick();
        chk("ins_done", 32'(done_o), 32'd1);
        chk("ins_ev", 32'(entry_valid_o), 32'h08);
        tick();
        chk("ins_done_pulse", 32'(done_o), 32'd0);

        // Duplicate key eviction
        send(1'b1, 3'd2, 20'h0ABCD);
        tick(); tick(); tick();
        chk("pre_dup_ev", 32'(entry_valid_o), 32'h0C);
        send(1'b1, 3'd5, 20'h0ABCD);
        chk("dup_upd", 32'(cam_update_o), 32'h04);
        chk("dup_vld", 32'(cam_set_valid_o), 32'd0);
        chk("dup_key", 32'(cam_set_key_o), 32'h0ABCD);
        tick();
        chk("dup_gap", 32'(cam_update_o), 32'h0);
        chk("dup_gap_ev", 32'(entry_valid_o), 32'h08);
        tick();
        chk("dup_issue", 32'(cam_update_o), 32'h20);
        chk("dup_issue_vld", 32'(cam_set_valid_o), 32'd1);
        tick(); tick();
        chk("dup_done", 32'(done_o), 32'd1);
        chk("dup_ev", 32'(entry_valid_o), 32'h28);
        tick();

        // Invalidate already-invalid entry, then a valid one
        send(1'b0, 3'd6, 20'h0);
        chk("inv6_upd", 32'(cam_update_o), 32'h40);
        chk("inv6_vld", 32'(cam_set_valid_o), 32'd0);
        tick(); tick();
        chk("inv6_done", 32'(done_o), 32'd1);
        chk("inv6_ev", 32'(entry_valid_o), 32'h28);
        tick();
        send(1'b0, 3'd3, 20'h0);
        chk("inv3_upd", 32'(cam_update_o), 32'h08);
        chk("inv3_key", 32'(cam_set_key_o), 32'h12345);
        tick(); tick();
        chk("inv3_ev", 32'(entry_valid_o), 32'h20);
        tick();

        // Back-to-back inserts to entry 1 with valid held high
        rif.req_valid_i = 1'b1;
        rif.req_op_i    = 1'b1;
        rif.req_idx_i   = 3'd1;
        rif.req_key_i   = 20'h00111;
        wait_ready("b2b_accept");
        tick();
        chk("b2b_upd1", 32'(cam_update_o), 32'h02);
        tick();
        chk("b2b_settle", 32'(cam_update_o), 32'h0);
        tick();
        chk("b2b_done", 32'(done_o), 32'd1);
        chk("b2b_ready", 32'(rif.req_ready_o), 32'd1);
        chk("b2b_done_upd", 32'(cam_update_o), 32'h0);
        tick();
        rif.req_valid_i = 1'b0;
        chk("b2b_upd2", 32'(cam_update_o), 32'h02);
        tick(); tick();
        chk("b2b_done2", 32'(done_o), 32'd1);
        chk("b2b_ev", 32'(entry_valid_o), 32'h22);
        tick();

        // Flush arriving mid-operation is deferred to DONE
        send(1'b1, 3'd4, 20'h00222);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        chk("fl_done", 32'(done_o), 32'd1);
        chk("fl_ready", 32'(rif.req_ready_o), 32'd0);
        tick();
        chk("fl_init_stable", 32'(stable_o), 32'd0);
        chk("fl_init_ev", 32'(entry_valid_o), 32'h0);
        chk("fl_init_upd", 32'(cam_update_o), 32'h01);
        wait_ready("fl_recover");

        // Flush and request together in IDLE: flush wins
        send(1'b1, 3'd0, 20'h00333);
        tick(); tick(); tick();
        chk("pre_fl2_ev", 32'(entry_valid_o), 32'h01);
        rif.req_valid_i = 1'b1;
        rif.req_idx_i   = 3'd7;
        flush_i = 1'b1;
        #1;
        chk("fl2_ready", 32'(rif.req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        rif.req_valid_i = 1'b0;
        chk("fl2_stable", 32'(stable_o), 32'd0);
        chk("fl2_ev", 32'(entry_valid_o), 32'h0);
        chk("fl2_upd", 32'(cam_update_o), 32'h01);
        wait_ready("fl2_recover");

        // Reset during SETTLE
        send(1'b1, 3'd2, 20'h00444);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rs_upd", 32'(cam_update_o), 32'h0);
        chk("rs_ev", 32'(entry_valid_o), 32'h0);
        chk("rs_stable", 32'(stable_o), 32'd0);
        chk("rs_ready", 32'(rif.req_ready_o), 32'd0);
        chk("rs_done", 32'(done_o), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rs_sweep0", 32'(cam_update_o), 32'h01);
        tick();
        chk("rs_sweep_gap", 32'(cam_update_o), 32'h0);
        tick();
        chk("rs_sweep1", 32'(cam_update_o), 32'h02);
        wait_ready("rs_recover");

        chk("protocol", 32'(proto_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
